// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: shifts in DATA_BITS data bits LSB-first, accumulates their XOR,
// then compares against a trailing parity bit and offers the result on a valid/ready port.
module serial_parity_checker #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 par_calc,
  output logic                 par_err,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_calc;
  logic                 r_par_err;
  logic                 r_frame_valid;
  logic                 r_bit_ready;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_par;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift;

  assign w_accept  = bit_valid & r_bit_ready;
  assign w_par     = r_acc ^ ODD_PARITY;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // New bit enters at the MSB so the first received bit ends up at [0]
  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign w_shift = bit_in;
    end else begin : g_shift_many
      assign w_shift = {bit_in, r_data[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= 1'b0;
      r_cnt         <= '0;
      r_data        <= '0;
      r_par_calc    <= 1'b0;
      r_par_err     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_bit_ready   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_DATA;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_bit_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_data <= w_shift;
            r_acc  <= r_acc ^ bit_in;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_W'(DATA_BITS)) begin
              r_state <= S_PAR;
            end
          end
        end
        S_PAR: begin
          if (w_accept) begin
            r_par_calc    <= w_par;
            r_par_err     <= w_par ^ bit_in;
            r_state       <= S_DONE;
            r_bit_ready   <= 1'b0;
            r_frame_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Results stay frozen until the downstream handshake completes
          if (frame_ready) begin
            r_state       <= S_IDLE;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_frame_valid <= 1'b0;
          r_bit_ready   <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready   = r_bit_ready;
  assign data_out    = r_data;
  assign par_calc    = r_par_calc;
  assign par_err     = r_par_err;
  assign frame_valid = r_frame_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even and odd instances share stimulus and
// are checked against a scoreboard of expected frames.
module tb_serial_parity_checker;

  localparam int unsigned DB = 8;

  typedef struct {
    logic [DB-1:0] data;
    logic          pc;
    logic          pe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst, start, bit_in, bit_valid, frame_ready;
  logic          br_e, pc_e, pe_e, fv_e, busy_e;
  logic          br_o, pc_o, pe_o, fv_o, busy_o;
  logic [DB-1:0] do_e, do_o;

  serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_e), .data_out(do_e), .par_calc(pc_e), .par_err(pe_e),
    .frame_valid(fv_e), .frame_ready(frame_ready), .busy(busy_e)
  );

  serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(br_o), .data_out(do_o), .par_calc(pc_o), .par_err(pe_o),
    .frame_valid(fv_o), .frame_ready(frame_ready), .busy(busy_o)
  );

  exp_t sb_even[$];
  exp_t sb_odd[$];
  exp_t last_e, last_o;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_data"}, 32'(do_e), 32'h0);
    check({tag, "_pc"}, 32'(pc_e), 32'h0);
    check({tag, "_pe"}, 32'(pe_e), 32'h0);
    check({tag, "_fv"}, 32'(fv_e), 32'h0);
    check({tag, "_br"}, 32'(br_e), 32'h0);
    check({tag, "_busy"}, 32'(busy_e), 32'h0);
  endtask

  // Drive one frame; the start cycle also carries a stray valid bit that must be ignored
  task automatic send_frame(input logic [DB-1:0] w, input logic pbit, input int max_gap,
                            input int mid_start_idx, output int unsigned fv_cyc);
    exp_t e, o;
    logic acc;
    int   k;
    acc    = ^w;
    e.data = w; e.pc = acc;        e.pe = acc ^ pbit;
    o.data = w; o.pc = acc ^ 1'b1; o.pe = acc ^ 1'b1 ^ pbit;
    sb_even.push_back(e);
    sb_odd.push_back(o);
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b0;
    check("start_busy", 32'(busy_e), 32'h1);
    check("start_br", 32'(br_e), 32'h1);
    for (int i = 0; i <= int'(DB); i++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        step();
      end
      bit_valid = 1'b1;
      bit_in    = (i < int'(DB)) ? w[i] : pbit;
      start     = (i == mid_start_idx);
      step();
      bit_valid = 1'b0;
      start     = 1'b0;
    end
    k = 0;
    while (!fv_e && k < 4) begin
      step();
      k++;
    end
    check("fv_rise_latency", 32'(k), 32'h0);
    check("fv_even", 32'(fv_e), 32'h1);
    check("fv_odd", 32'(fv_o), 32'h1);
    fv_cyc = cyc;
    e = sb_even.pop_front();
    o = sb_odd.pop_front();
    check("data_even", 32'(do_e), 32'(e.data));
    check("pc_even", 32'(pc_e), 32'(e.pc));
    check("pe_even", 32'(pe_e), 32'(e.pe));
    check("data_odd", 32'(do_o), 32'(o.data));
    check("pc_odd", 32'(pc_o), 32'(o.pc));
    check("pe_odd", 32'(pe_o), 32'(o.pe));
    check("done_br", 32'(br_e), 32'h0);
    last_e = e;
    last_o = o;
  endtask

  task automatic handshake(input logic with_start);
    frame_ready = 1'b1;
    start       = with_start;
    step();
    frame_ready = 1'b0;
    start       = 1'b0;
    check("hs_fv_drop", 32'(fv_e), 32'h0);
    check("hs_busy", 32'(busy_e), 32'h0);
    check("hs_hold_data", 32'(do_e), 32'(last_e.data));
    check("hs_hold_pe", 32'(pe_e), 32'(last_e.pe));
  endtask

  initial begin
    int unsigned t1, t2;
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_ready = 1'b0;
    step();
    step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy_e), 32'h0);

    // A5 with correct and wrong parity
    send_frame(8'hA5, 1'b0, 0, -1, t1);
    handshake(1'b0);
    send_frame(8'hA5, 1'b1, 0, -1, t1);
    handshake(1'b0);

    // 07 exercises the odd-parity instance
    send_frame(8'h07, 1'b0, 0, -1, t1);
    handshake(1'b0);
    send_frame(8'h07, 1'b1, 0, -1, t1);
    handshake(1'b0);

    // Random stalls, then DONE held without frame_ready
    send_frame(8'h5E, 1'b1, 3, -1, t1);
    for (int h = 0; h < 5; h++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      step();
      check("hold_fv", 32'(fv_e), 32'h1);
      check("hold_br", 32'(br_e), 32'h0);
      check("hold_data", 32'(do_e), 32'(last_e.data));
      check("hold_pc", 32'(pc_e), 32'(last_e.pc));
      check("hold_pe", 32'(pe_e), 32'(last_e.pe));
    end
    bit_valid = 1'b0;
    handshake(1'b0);

    // Reset in the middle of a frame
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'(i & 1);
      step();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_fv", 32'(fv_e), 32'h0);
    end
    send_frame(8'h3C, 1'b0, 1, -1, t1);
    handshake(1'b0);

    // Ignored starts in DATA and DONE, then back-to-back frame spacing
    send_frame(8'hC9, 1'b0, 0, 3, t1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_fv", 32'(fv_e), 32'h1);
    check("done_start_data", 32'(do_e), 32'(last_e.data));
    handshake(1'b1);
    step();
    check("hs_start_ignored", 32'(busy_e), 32'h0);

    send_frame(8'h96, 1'b0, 0, -1, t1);
    handshake(1'b0);
    send_frame(8'h61, 1'b1, 0, -1, t2);
    check("frame_period", 32'(t2 - t1), 32'(DB + 3));
    handshake(1'b0);

    check("sb_empty", 32'(sb_even.size() + sb_odd.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
